// File: rtl/vx_gfx_mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : vx_gfx_mem_arb
// Purpose  : Round-robin arbiter merging the graphics cache memory ports onto
//            one L2 port, with a registered request stage, requester-index
//            tag extension for response routing and per-requester read
//            outstanding limits.
// Revision : 1.0 - initial release
// ============================================================================
module vx_gfx_mem_arb #(
  parameter int NUM_REQS    = 3,
  parameter int ADDR_WIDTH  = 26,
  parameter int DATA_SIZE   = 64,
  parameter int TAG_WIDTH   = 8,
  parameter int MAX_PENDING = 16,
  parameter int SEL_BITS    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
  parameter int OTAG_WIDTH  = TAG_WIDTH + SEL_BITS,
  parameter int CNT_W       = $clog2(MAX_PENDING + 1)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_REQS-1:0]                in_req_valid,
  input  logic [NUM_REQS-1:0]                in_req_rw,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0]     in_req_addr,
  input  logic [NUM_REQS*DATA_SIZE*8-1:0]    in_req_data,
  input  logic [NUM_REQS*DATA_SIZE-1:0]      in_req_byteen,
  input  logic [NUM_REQS*TAG_WIDTH-1:0]      in_req_tag,
  output logic [NUM_REQS-1:0]                in_req_ready,
  output logic [NUM_REQS-1:0]                in_rsp_valid,
  output logic [DATA_SIZE*8-1:0]             in_rsp_data,
  output logic [TAG_WIDTH-1:0]               in_rsp_tag,
  input  logic [NUM_REQS-1:0]                in_rsp_ready,
  output logic                               mem_req_valid,
  output logic                               mem_req_rw,
  output logic [ADDR_WIDTH-1:0]              mem_req_addr,
  output logic [DATA_SIZE*8-1:0]             mem_req_data,
  output logic [DATA_SIZE-1:0]               mem_req_byteen,
  output logic [OTAG_WIDTH-1:0]              mem_req_tag,
  input  logic                               mem_req_ready,
  input  logic                               mem_rsp_valid,
  input  logic [DATA_SIZE*8-1:0]             mem_rsp_data,
  input  logic [OTAG_WIDTH-1:0]              mem_rsp_tag,
  output logic                               mem_rsp_ready
);

  logic [SEL_BITS-1:0]              ptr;
  logic [NUM_REQS-1:0][CNT_W-1:0]   pend;
  logic [NUM_REQS-1:0]              eligible;
  logic [SEL_BITS-1:0]              winner;
  logic                             any_elig;
  logic                             free;
  logic                             accept;
  logic [SEL_BITS-1:0]              rsp_sel;

  // Eligibility and round-robin winner search starting at ptr.
  always_comb begin
    eligible = '0;
    winner   = '0;
    any_elig = 1'b0;
    for (int i = 0; i < NUM_REQS; i++) begin
      // Only reads consume L2 MSHRs, so only reads are throttled.
      eligible[i] = in_req_valid[i] &&
                    !(!in_req_rw[i] && (pend[i] == CNT_W'(MAX_PENDING)));
    end
    for (int k = 0; k < NUM_REQS; k++) begin
      int idx;
      idx = (int'(ptr) + k) % NUM_REQS;
      if (!any_elig && eligible[idx]) begin
        any_elig = 1'b1;
        winner   = SEL_BITS'(idx);
      end
    end
  end

  assign free   = !mem_req_valid || mem_req_ready;
  assign accept = reset && free && any_elig;

  // One-hot ready to the winner only when the output stage can take it.
  always_comb begin
    in_req_ready = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      in_req_ready[i] = accept && (winner == SEL_BITS'(i));
    end
  end

  // Output-stage valid and round-robin pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req_valid <= 1'b0;
      ptr           <= '0;
    end else begin
      if (free) begin
        mem_req_valid <= any_elig;
      end
      if (accept) begin
        ptr <= (int'(winner) == NUM_REQS - 1) ? '0 : winner + 1'b1;
      end
    end
  end

  // Payload capture; contents are irrelevant while mem_req_valid is low.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_req_rw     <= in_req_rw[winner];
      mem_req_addr   <= in_req_addr[winner*ADDR_WIDTH +: ADDR_WIDTH];
      mem_req_data   <= in_req_data[winner*DATA_SIZE*8 +: DATA_SIZE*8];
      mem_req_byteen <= in_req_byteen[winner*DATA_SIZE +: DATA_SIZE];
      mem_req_tag    <= {in_req_tag[winner*TAG_WIDTH +: TAG_WIDTH], winner};
    end
  end

  // Outstanding-read counters; simultaneous inc/dec cancel, floor at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend <= '0;
    end else begin
      for (int i = 0; i < NUM_REQS; i++) begin
        if ((in_req_ready[i] && !in_req_rw[i]) &&
            !(in_rsp_valid[i] && in_rsp_ready[i])) begin
          pend[i] <= pend[i] + 1'b1;
        end else if (!(in_req_ready[i] && !in_req_rw[i]) &&
                     (in_rsp_valid[i] && in_rsp_ready[i]) &&
                     (pend[i] != '0)) begin
          pend[i] <= pend[i] - 1'b1;
        end
      end
    end
  end

  assign rsp_sel     = mem_rsp_tag[SEL_BITS-1:0];
  assign in_rsp_data = mem_rsp_data;
  assign in_rsp_tag  = mem_rsp_tag[OTAG_WIDTH-1:SEL_BITS];

  // Response demux; an out-of-range index is consumed and dropped.
  always_comb begin
    in_rsp_valid  = '0;
    mem_rsp_ready = 1'b1;
    for (int i = 0; i < NUM_REQS; i++) begin
      in_rsp_valid[i] = mem_rsp_valid && (rsp_sel == SEL_BITS'(i));
      if (rsp_sel == SEL_BITS'(i)) begin
        mem_rsp_ready = in_rsp_ready[i];
      end
    end
  end

  // Flag responses carrying a requester index that does not exist.
  always @(posedge clk) begin
    if (reset && mem_rsp_valid) begin
      assert (int'(rsp_sel) < NUM_REQS)
        else $warning("vx_gfx_mem_arb: dropped response with requester index %0d", rsp_sel);
    end
  end

endmodule
`default_nettype wire
